jtframe_ioctl_prog: RTL and testbench
=====================================

// Module: jtframe_ioctl_prog
// PURPOSE
//  Converts the byte stream of the SPI/ioctl ROM loader (ioctl_addr/dout/wr) into SDRAM
//  programming writes (prog_addr/data/mask/ba/we) for the board SDRAM controller.
//  Sits between the MiST base ioctl outputs and the prog_* inputs of the frame top.
//  Buffers bursty bytes in a small FIFO, maps addresses to banks, and reports busy.
// PARAMETERS
//  SDRAMW     23        prog_addr width (16-bit word address)
//  BA1_START  25'h0     byte address where bank 1 begins (0 = bank unused)
//  BA2_START  25'h0     byte address where bank 2 begins (0 = bank unused)
//  BA3_START  25'h0     byte address where bank 3 begins (0 = bank unused)
//  SWAB       0         1: even byte goes to data[15:8] instead of data[7:0]
//  FIFOAW     2         log2 of FIFO depth (depth = 4)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous reset, active high
//  downloading  in   1       loader active
//  ioctl_addr   in   25      byte address of ioctl_dout
//  ioctl_dout   in   8       byte from loader
//  ioctl_wr     in   1       one-cycle byte strobe
//  prog_addr    out  SDRAMW  word address within selected bank
//  prog_data    out  16      byte replicated in both halves
//  prog_mask    out  2       active-low byte enables
//  prog_ba      out  2       SDRAM bank
//  prog_we      out  1       write request, held until prog_rdy
//  prog_rdy     in   1       SDRAM controller: write done
//  dwnld_busy   out  1       download or drain in progress
//  overflow     out  1       sticky: a byte was dropped
// BEHAVIOUR
//  - Reset: prog_we=0, prog_addr=0, prog_data=0, prog_mask=2'b11, prog_ba=0, dwnld_busy=0,
//    overflow=0; FIFO emptied, FSM to IDLE. Reset mid-write drops prog_we next cycle; pending data lost.
//  - Bank map (compare on ioctl_addr at push): addr>=BA3_START&&BA3_START!=0 -> ba3, offset
//    addr-BA3_START; else same for BA2, BA1; else ba0, offset addr. Starts must be even, ascending.
//  - prog_addr = offset[SDRAMW:1]; higher offset bits discarded (wrap within bank).
//  - SWAB=0: offset[0]=0 -> mask 2'b10 (low byte), =1 -> 2'b01. SWAB=1 swaps these.
//  - prog_data = {byte,byte} always; mask selects the lane.
//  - FIFO entry = {ba, word addr, byte, lane}; push on ioctl_wr. Push while full and no pop
//    in same cycle -> byte dropped, overflow<=1. Push+pop same cycle when full -> accepted.
//  - overflow clears on rst or on rising edge of downloading; otherwise sticky.
//  - FSM IDLE: FIFO non-empty -> load outputs from head, pop, prog_we<=1, go WAIT.
//    WAIT: hold prog_we/addr/data/mask/ba stable; prog_rdy=1 -> prog_we<=0, go GAP.
//    GAP: one cycle with prog_we=0, then IDLE. prog_rdy outside WAIT is ignored.
//  - Latency: ioctl_wr sampled at edge N with FIFO empty and FSM IDLE -> prog_we high after
//    edge N+2. Throughput: one write per 3 cycles min (IDLE,WAIT,GAP) when prog_rdy immediate.
//  - dwnld_busy = downloading | FIFO non-empty | FSM!=IDLE, registered (1-cycle delay).
//    Falls only after last write completes, even if downloading fell earlier.
//  - ioctl_wr while downloading=0 is still accepted (cheat/NVRAM reloads share path).
// TESTING
//  1 Bank0: wr addr 0x000 data 0x12, addr 0x001 data 0x34, prog_rdy 1 cycle after we ->
//    prog_addr=0 data=0x1212 mask=2'b10, then prog_addr=0 data=0x3434 mask=2'b01, ba=0.
//  2 BA1_START=0x100000: wr addr 0x100005 -> prog_ba=1, prog_addr=2, mask=2'b01.
//  3 prog_rdy held low 50 cycles, 6 bytes on consecutive cycles -> 4 queued + 1 in WAIT,
//    6th dropped, overflow=1; rising downloading clears it.
//  4 downloading falls with 3 bytes queued -> dwnld_busy stays 1 until third prog_rdy + 2 cycles.
//  5 rst asserted in WAIT -> prog_we=0 next cycle, FIFO empty, later prog_rdy ignored.
//  6 SWAB=1: wr addr 0x000 data 0xAB -> mask=2'b01, data=0xABAB.

Source files
------------

// File: rtl/jtframe_ioctl_prog.sv
// ============================================================================
// Module      : jtframe_ioctl_prog
// Description : Turns the ioctl ROM-loader byte stream into SDRAM programming
//               writes, with bank mapping, a small FIFO and busy/overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtframe_ioctl_prog #(
    parameter int          SDRAMW    = 23,
    parameter logic [24:0] BA1_START = 25'h0,
    parameter logic [24:0] BA2_START = 25'h0,
    parameter logic [24:0] BA3_START = 25'h0,
    parameter logic        SWAB      = 1'b0,
    parameter int          FIFOAW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic [1:0]        prog_mask,
    output logic [1:0]        prog_ba,
    output logic              prog_we,
    input  logic              prog_rdy,
    output logic              dwnld_busy,
    output logic              overflow
);

    localparam int c_DEPTH = 1 << FIFOAW;
    // Entry layout: {ba[1:0], word address, byte, lane}
    localparam int c_EW    = 2 + SDRAMW + 8 + 1;

    localparam logic [FIFOAW:0]   c_FULL_CNT = {1'b1, {FIFOAW{1'b0}}};
    localparam logic [FIFOAW:0]   c_CNT_ONE  = {{FIFOAW{1'b0}}, 1'b1};
    localparam logic [FIFOAW-1:0] c_PTR_ONE  = {{(FIFOAW-1){1'b0}}, 1'b1};

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_WAIT = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;

    // ------------------------------------------------------------------
    // Bank mapping of the incoming byte address
    // ------------------------------------------------------------------
    logic [1:0]        w_ba;
    logic [24:0]       w_off;
    logic [SDRAMW-1:0] w_word;
    logic              w_lane;
    logic [c_EW-1:0]   w_entry;

    always_comb begin
        w_ba  = 2'd0;
        w_off = ioctl_addr;
        if (BA3_START != 25'd0 && ioctl_addr >= BA3_START) begin
            w_ba  = 2'd3;
            w_off = ioctl_addr - BA3_START;
        end else if (BA2_START != 25'd0 && ioctl_addr >= BA2_START) begin
            w_ba  = 2'd2;
            w_off = ioctl_addr - BA2_START;
        end else if (BA1_START != 25'd0 && ioctl_addr >= BA1_START) begin
            w_ba  = 2'd1;
            w_off = ioctl_addr - BA1_START;
        end
    end

    // Offset bits above the word address are dropped, wrapping within the bank
    assign w_word  = SDRAMW'(w_off >> 1);
    assign w_lane  = w_off[0] ^ SWAB;
    assign w_entry = {w_ba, w_word, ioctl_dout, w_lane};

    // ------------------------------------------------------------------
    // Input staging register (one cycle between strobe and FIFO push)
    // ------------------------------------------------------------------
    logic            r_in_valid;
    logic [c_EW-1:0] r_in_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_valid <= 1'b0;
        end else begin
            r_in_valid <= ioctl_wr;
        end
    end

    always_ff @(posedge clk) begin
        if (ioctl_wr) begin
            r_in_entry <= w_entry;
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [c_EW-1:0]   r_mem [c_DEPTH];
    logic [FIFOAW-1:0] r_wr_ptr;
    logic [FIFOAW-1:0] r_rd_ptr;
    logic [FIFOAW:0]   r_count;
    logic [1:0]        r_state;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_count == c_FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = (r_state == c_ST_IDLE) && !w_empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle
    assign w_push  = r_in_valid && (!w_full || w_pop);
    assign w_drop  = r_in_valid && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    logic [c_EW-1:0]   w_head;
    logic [1:0]        w_head_ba;
    logic [SDRAMW-1:0] w_head_addr;
    logic [7:0]        w_head_byte;
    logic              w_head_lane;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_ba   = w_head[c_EW-1 -: 2];
    assign w_head_addr = w_head[SDRAMW+8 -: SDRAMW];
    assign w_head_byte = w_head[8:1];
    assign w_head_lane = w_head[0];

    // ------------------------------------------------------------------
    // Write handshake FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            prog_we   <= 1'b0;
            prog_addr <= '0;
            prog_data <= 16'h0000;
            prog_mask <= 2'b11;
            prog_ba   <= 2'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        prog_addr <= w_head_addr;
                        prog_data <= {w_head_byte, w_head_byte};
                        prog_mask <= w_head_lane ? 2'b01 : 2'b10;
                        prog_ba   <= w_head_ba;
                        prog_we   <= 1'b1;
                        r_state   <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (prog_rdy) begin
                        prog_we <= 1'b0;
                        r_state <= c_ST_GAP;
                    end
                end
                c_ST_GAP: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    prog_we <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status flags
    // ------------------------------------------------------------------
    logic r_dl_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dl_prev  <= 1'b0;
            overflow   <= 1'b0;
            dwnld_busy <= 1'b0;
        end else begin
            r_dl_prev  <= downloading;
            dwnld_busy <= downloading | r_in_valid | !w_empty | (r_state != c_ST_IDLE);
            // A drop in the same cycle as a new download start is still reported
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (downloading && !r_dl_prev) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jtframe_ioctl_prog.sv
// ============================================================================
// Module      : tb_jtframe_ioctl_prog
// Description : Directed vector bench for jtframe_ioctl_prog (banked and SWAB).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtframe_ioctl_prog;

    logic        clk = 1'b0;
    logic        rst;
    logic        downloading;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic        prog_rdy;

    logic [22:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        dwnld_busy;
    logic        overflow;

    logic [22:0] s_prog_addr;
    logic [15:0] s_prog_data;
    logic [1:0]  s_prog_mask;
    logic [1:0]  s_prog_ba;
    logic        s_prog_we;
    logic        s_dwnld_busy;
    logic        s_overflow;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    jtframe_ioctl_prog #(
        .SDRAMW    (23),
        .BA1_START (25'h100000),
        .BA2_START (25'h200000),
        .BA3_START (25'h300000),
        .SWAB      (1'b0),
        .FIFOAW    (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_ba     (prog_ba),
        .prog_we     (prog_we),
        .prog_rdy    (prog_rdy),
        .dwnld_busy  (dwnld_busy),
        .overflow    (overflow)
    );

    jtframe_ioctl_prog #(
        .SDRAMW    (23),
        .BA1_START (25'h0),
        .BA2_START (25'h0),
        .BA3_START (25'h0),
        .SWAB      (1'b1),
        .FIFOAW    (2)
    ) dut_swab (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (s_prog_addr),
        .prog_data   (s_prog_data),
        .prog_mask   (s_prog_mask),
        .prog_ba     (s_prog_ba),
        .prog_we     (s_prog_we),
        .prog_rdy    (prog_rdy),
        .dwnld_busy  (s_dwnld_busy),
        .overflow    (s_overflow)
    );

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  din;
        logic [1:0]  ba;
        logic [22:0] waddr;
        logic [15:0] data;
        logic [1:0]  mask;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_we(input string name, input int max_cycles);
        int k;
        k = 0;
        while (prog_we !== 1'b1 && k < max_cycles) begin
            step();
            k++;
        end
        check(name, {31'b0, prog_we}, 32'd1);
    endtask

    task automatic check_write(input string tag, input logic [1:0] ba, input logic [22:0] addr,
                               input logic [15:0] data, input logic [1:0] mask);
        check({tag, "_we"},   {31'b0, prog_we},   32'd1);
        check({tag, "_ba"},   {30'b0, prog_ba},   {30'b0, ba});
        check({tag, "_addr"}, {9'b0, prog_addr},  {9'b0, addr});
        check({tag, "_data"}, {16'b0, prog_data}, {16'b0, data});
        check({tag, "_mask"}, {30'b0, prog_mask}, {30'b0, mask});
    endtask

    // Completes the current write and checks the next one from the FIFO
    task automatic next_write(input string tag, input logic [22:0] addr,
                              input logic [15:0] data, input logic [1:0] mask);
        prog_rdy = 1'b1;
        step();
        prog_rdy = 1'b0;
        step();
        step();
        check_write(tag, 2'd0, addr, data, mask);
    endtask

    initial begin
        vecs[0] = '{25'h0000000, 8'h12, 2'd0, 23'h000000, 16'h1212, 2'b10};
        vecs[1] = '{25'h0000001, 8'h34, 2'd0, 23'h000000, 16'h3434, 2'b01};
        vecs[2] = '{25'h0100005, 8'h5A, 2'd1, 23'h000002, 16'h5A5A, 2'b01};
        vecs[3] = '{25'h00FFFFF, 8'hC3, 2'd0, 23'h07FFFF, 16'hC3C3, 2'b01};
        vecs[4] = '{25'h0200000, 8'h77, 2'd2, 23'h000000, 16'h7777, 2'b10};
        vecs[5] = '{25'h02ABCDE, 8'h9E, 2'd2, 23'h055E6F, 16'h9E9E, 2'b10};
        vecs[6] = '{25'h03FFFFF, 8'hFF, 2'd3, 23'h07FFFF, 16'hFFFF, 2'b01};
        vecs[7] = '{25'h1FFFFFF, 8'h01, 2'd3, 23'h67FFFF, 16'h0101, 2'b01};
        vecs[8] = '{25'h0000000, 8'hAB, 2'd0, 23'h000000, 16'hABAB, 2'b10};

        rst         = 1'b1;
        downloading = 1'b0;
        ioctl_addr  = '0;
        ioctl_dout  = '0;
        ioctl_wr    = 1'b0;
        prog_rdy    = 1'b0;
        repeat (3) step();

        check("rst_we",       {31'b0, prog_we},    32'd0);
        check("rst_addr",     {9'b0, prog_addr},   32'd0);
        check("rst_data",     {16'b0, prog_data},  32'd0);
        check("rst_mask",     {30'b0, prog_mask},  32'd3);
        check("rst_ba",       {30'b0, prog_ba},    32'd0);
        check("rst_busy",     {31'b0, dwnld_busy}, 32'd0);
        check("rst_overflow", {31'b0, overflow},   32'd0);
        rst = 1'b0;
        step();
        check("idle_busy", {31'b0, dwnld_busy}, 32'd0);

        // Table of single writes: exact latency, field values, hold, and GAP
        for (int i = 0; i < 9; i++) begin
            ioctl_addr = vecs[i].addr;
            ioctl_dout = vecs[i].din;
            ioctl_wr   = 1'b1;
            step();
            ioctl_wr = 1'b0;
            step();
            check($sformatf("v%0d_we_early", i), {31'b0, prog_we}, 32'd0);
            step();
            check_write($sformatf("v%0d", i), vecs[i].ba, vecs[i].waddr, vecs[i].data, vecs[i].mask);
            check($sformatf("v%0d_busy", i), {31'b0, dwnld_busy}, 32'd1);
            check($sformatf("v%0d_swab_mask", i), {30'b0, s_prog_mask},
                  {30'b0, vecs[i].mask[0], vecs[i].mask[1]});
            check($sformatf("v%0d_swab_data", i), {16'b0, s_prog_data}, {16'b0, vecs[i].data});
            step();
            check($sformatf("v%0d_hold_we", i), {31'b0, prog_we}, 32'd1);
            check($sformatf("v%0d_hold_addr", i), {9'b0, prog_addr}, {9'b0, vecs[i].waddr});
            prog_rdy = 1'b1;
            step();
            check($sformatf("v%0d_gap_we", i), {31'b0, prog_we}, 32'd0);
            prog_rdy = 1'b0;
            step();
        end

        // Overflow: six back-to-back bytes with the controller stalled
        downloading = 1'b1;
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            ioctl_addr = 25'h10 + 25'(i);
            ioctl_dout = 8'hA0 + 8'(i);
            ioctl_wr   = 1'b1;
            step();
        end
        ioctl_wr = 1'b0;
        check("ovf_before_drop", {31'b0, overflow}, 32'd0);
        check_write("ovf_head", 2'd0, 23'h8, 16'hA0A0, 2'b10);
        step();
        check("ovf_set", {31'b0, overflow}, 32'd1);
        repeat (43) step();
        check("ovf_stall_we",   {31'b0, prog_we},  32'd1);
        check("ovf_stall_flag", {31'b0, overflow}, 32'd1);
        next_write("ovf_b1", 23'h8, 16'hA1A1, 2'b01);
        next_write("ovf_b2", 23'h9, 16'hA2A2, 2'b10);
        next_write("ovf_b3", 23'h9, 16'hA3A3, 2'b01);
        next_write("ovf_b4", 23'hA, 16'hA4A4, 2'b10);
        prog_rdy = 1'b1;
        step();
        prog_rdy = 1'b0;
        repeat (3) step();
        check("ovf_drained_we", {31'b0, prog_we},  32'd0);
        check("ovf_sticky",     {31'b0, overflow}, 32'd1);
        downloading = 1'b0;
        step();
        check("ovf_sticky_fall", {31'b0, overflow}, 32'd1);
        downloading = 1'b1;
        step();
        step();
        check("ovf_cleared", {31'b0, overflow}, 32'd0);

        // Busy must outlast downloading until the last queued write finishes
        for (int i = 0; i < 3; i++) begin
            ioctl_addr = 25'h20 + 25'(i);
            ioctl_dout = 8'h01 + 8'(i);
            ioctl_wr   = 1'b1;
            step();
        end
        ioctl_wr    = 1'b0;
        downloading = 1'b0;
        repeat (5) step();
        check("busy_after_dl_fall", {31'b0, dwnld_busy}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            wait_we($sformatf("busy_w%0d_timeout", k), 10);
            check($sformatf("busy_w%0d_addr", k), {9'b0, prog_addr}, 32'h10 + 32'(k >> 1));
            check($sformatf("busy_w%0d_busy", k), {31'b0, dwnld_busy}, 32'd1);
            prog_rdy = 1'b1;
            step();
            prog_rdy = 1'b0;
        end
        check("busy_rdy_p0", {31'b0, dwnld_busy}, 32'd1);
        step();
        check("busy_rdy_p1", {31'b0, dwnld_busy}, 32'd1);
        step();
        check("busy_rdy_p2", {31'b0, dwnld_busy}, 32'd0);

        // Reset while a write is pending in WAIT
        downloading = 1'b1;
        ioctl_addr  = 25'h30;
        ioctl_dout  = 8'h55;
        ioctl_wr    = 1'b1;
        step();
        ioctl_addr = 25'h31;
        ioctl_dout = 8'h66;
        step();
        ioctl_wr = 1'b0;
        wait_we("rstw_timeout", 10);
        check_write("rstw", 2'd0, 23'h18, 16'h5555, 2'b10);
        rst = 1'b1;
        step();
        check("rstw_we",   {31'b0, prog_we},    32'd0);
        check("rstw_mask", {30'b0, prog_mask},  32'd3);
        check("rstw_busy", {31'b0, dwnld_busy}, 32'd0);
        rst      = 1'b0;
        prog_rdy = 1'b1;
        repeat (3) step();
        prog_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("rstw_empty%0d", k), {31'b0, prog_we}, 32'd0);
        end

        downloading = 1'b0;
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
